// File: rtl/mux_sel_seq.sv
// mux_sel_seq: steps the 2-bit select of the 4:1 LED pattern mux, automatically or per step edge.
// Optional ping-pong sequencing is enabled by defining MUX_SEL_SEQ_BOUNCE_EN.
module mux_sel_seq #(
  parameter int               DIV_W   = 26,
  parameter logic [DIV_W-1:0] DIV_MAX = 26'd49_999_999
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic dir,
  input  logic step,
  input  logic bounce,
  output logic sel0,
  output logic sel1,
  output logic tick,
  output logic wrap
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt;
  logic [1:0]       sel;
  logic             step_q;
  logic             auto_ev;
  logic             man_ev;
  logic             adv;
  logic             move_down;
  logic             wrap_nxt;
  logic [1:0]       sel_nxt;

  assign auto_ev = run && (cnt == DIV_MAX);
  assign man_ev  = step && !step_q;
  assign adv     = auto_ev || man_ev;

`ifdef MUX_SEL_SEQ_BOUNCE_EN
  localparam logic PP_UP   = 1'b0;
  localparam logic PP_DOWN = 1'b1;

  logic pp_dir;

  assign move_down = bounce ? pp_dir : dir;
  assign sel_nxt   = move_down ? (sel - 2'd1) : (sel + 2'd1);

  // Ping-pong flags every arrival at either end; normal mode flags only the wraparound.
  assign wrap_nxt  = bounce ? ((sel_nxt == 2'd3) || (sel_nxt == 2'd0))
                            : (move_down ? (sel_nxt == 2'd3) : (sel_nxt == 2'd0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pp_dir <= PP_UP;
    end else if (adv && bounce) begin
      if (sel_nxt == 2'd3) begin
        pp_dir <= PP_DOWN;
      end else if (sel_nxt == 2'd0) begin
        pp_dir <= PP_UP;
      end
    end
  end
`else
  logic unused_bounce;

  assign unused_bounce = bounce;
  assign move_down     = dir;
  assign sel_nxt       = move_down ? (sel - 2'd1) : (sel + 2'd1);
  assign wrap_nxt      = move_down ? (sel_nxt == 2'd3) : (sel_nxt == 2'd0);
`endif

  // A manual step restarts the prescaler so the next auto advance is a full period away.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt    <= '0;
      sel    <= 2'b00;
      tick   <= 1'b0;
      wrap   <= 1'b0;
      step_q <= 1'b1;
    end else begin
      step_q <= step;
      tick   <= adv;
      wrap   <= adv && wrap_nxt;
      if (adv) begin
        sel <= sel_nxt;
      end
      if (!run || adv) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign sel0 = sel[0];
  assign sel1 = sel[1];

endmodule

// File: tb/tb_mux_sel_seq.sv
// tb_mux_sel_seq: directed, table-driven self-checking bench for mux_sel_seq.
// Ping-pong expectations follow MUX_SEL_SEQ_BOUNCE_EN as seen by this compile.
module tb_mux_sel_seq;

  typedef struct {
    logic       run;
    logic       dir;
    logic       step;
    logic [1:0] sel;
    logic       tick;
    logic       wrap;
  } vec_t;

  logic clk;
  logic reset_n;
  logic run;
  logic dir;
  logic step;
  logic bounce;
  logic sel0_a, sel1_a, tick_a, wrap_a;
  logic sel0_b, sel1_b, tick_b, wrap_b;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  int tests;
  int fails;

  vec_t       vecs[16];
  logic [1:0] bexp_sel[8];
  logic       bexp_wrap[8];

  assign sel_a = {sel1_a, sel0_a};
  assign sel_b = {sel1_b, sel0_b};

  mux_sel_seq #(.DIV_W(26), .DIV_MAX(26'd3)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .step(step), .bounce(bounce),
    .sel0(sel0_a), .sel1(sel1_a), .tick(tick_a), .wrap(wrap_a)
  );

  mux_sel_seq #(.DIV_W(26), .DIV_MAX(26'd0)) dut_fast (
    .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .step(step), .bounce(bounce),
    .sel0(sel0_b), .sel1(sel1_b), .tick(tick_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic d, input logic s, input logic b);
    run    = r;
    dir    = d;
    step   = s;
    bounce = b;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [1:0] act_sel, input logic act_tick, input logic act_wrap,
                             input logic [1:0] exp_sel, input logic exp_tick, input logic exp_wrap);
    tests++;
    if (act_sel !== exp_sel || act_tick !== exp_tick || act_wrap !== exp_wrap) begin
      fails++;
      $display("[TB] FAIL %s: got sel=%0d tick=%b wrap=%b, expected sel=%0d tick=%b wrap=%b",
               name, act_sel, act_tick, act_wrap, exp_sel, exp_tick, exp_wrap);
    end
  endtask

  task automatic doReset(input logic r, input logic d, input logic s, input logic b);
    reset_n = 1'b0;
    applyStimulus(r, d, s, b);
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Manual stepping with run=0: isolated edges, a held step, and dir changes between steps.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};

`ifdef MUX_SEL_SEQ_BOUNCE_EN
    bexp_sel  = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
    bexp_wrap = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    bexp_sel  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bexp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

    // Reset state.
    cycle();
    cycle();
    checkOutput("reset", sel_a, tick_a, wrap_a, 2'd0, 1'b0, 1'b0);
    checkOutput("reset_fast", sel_b, tick_b, wrap_b, 2'd0, 1'b0, 1'b0);

    // Auto advance every DIV_MAX+1 = 4 cycles, counting up.
    doReset(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cycle();
      checkOutput($sformatf("auto_%0d", i), sel_a, tick_a, wrap_a,
                  2'((i / 4) % 4), (i % 4) == 0, i == 16);
    end

    // Table of manual steps.
    doReset(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("manual_idle", sel_a, tick_a, wrap_a, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].run, vecs[i].dir, vecs[i].step, 1'b0);
      cycle();
      checkOutput($sformatf("vec_%0d", i), sel_a, tick_a, wrap_a,
                  vecs[i].sel, vecs[i].tick, vecs[i].wrap);
    end

    // Step edge coinciding with the auto event: one advance, then a full period.
    doReset(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkOutput($sformatf("coinc_pre_%0d", i), sel_a, tick_a, wrap_a, 2'd0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("coinc_adv", sel_a, tick_a, wrap_a, 2'd1, 1'b1, 1'b0);
    for (int i = 5; i <= 7; i++) begin
      cycle();
      checkOutput($sformatf("coinc_hold_%0d", i), sel_a, tick_a, wrap_a, 2'd1, 1'b0, 1'b0);
    end
    cycle();
    checkOutput("coinc_next", sel_a, tick_a, wrap_a, 2'd2, 1'b1, 1'b0);

    // Step held high through reset must not advance until it drops and rises again.
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    cycle();
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkOutput($sformatf("step_held_%0d", i), sel_a, tick_a, wrap_a, 2'd0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("step_low", sel_a, tick_a, wrap_a, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("step_rise", sel_a, tick_a, wrap_a, 2'd1, 1'b1, 1'b0);

    // Reset landing on the edge that would have advanced from 2 to 3.
    doReset(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) cycle();
    checkOutput("midcount_pre", sel_a, tick_a, wrap_a, 2'd2, 1'b0, 1'b0);
    reset_n = 1'b0;
    cycle();
    checkOutput("midcount_reset", sel_a, tick_a, wrap_a, 2'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkOutput($sformatf("midcount_after_%0d", i), sel_a, tick_a, wrap_a, 2'd0, 1'b0, 1'b0);
    end
    cycle();
    checkOutput("midcount_adv", sel_a, tick_a, wrap_a, 2'd1, 1'b1, 1'b0);

    // Bounce request on the DIV_MAX=0 instance: advance every cycle.
    doReset(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      checkOutput($sformatf("bounce_%0d", i), sel_b, tick_b, wrap_b,
                  bexp_sel[i], 1'b1, bexp_wrap[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_sel_seq.md
# mux_sel_seq

Select-line sequencer that sits directly upstream of the 4:1 LED pattern mux and drives its `sel0`/`sel1` inputs. It steps the 2-bit selection through inputs 0..3, either automatically at a prescaled rate or one step per manual button edge. It also emits one-cycle pulses that downstream display logic uses to mark each change and each end-of-sequence.

## Interface
- `DIV_W`, 26: prescaler counter width.
- `DIV_MAX`, 26'd49_999_999: prescaler terminal count. The auto-advance period is DIV_MAX+1 cycles, which is 1 Hz at 50 MHz.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `run`  in  1  1 = auto-advance enabled.
- `dir`  in  1  0 = count up, 1 = count down.
- `step`  in  1  manual advance request, already synchronous to `clk`. Only the rising edge is used.
- `bounce`  in  1  ping-pong mode request. It is only effective when the configuration macro is defined.
- `sel0`  out  1  select bit 0, LSB of the selection.
- `sel1`  out  1  select bit 1, MSB of the selection.
- `tick`  out  1  one-cycle pulse in the cycle the selection takes a new value.
- `wrap`  out  1  one-cycle pulse when the selection reaches a sequence end (see Operation).

## Operation
- State:
  - prescaler `cnt[DIV_W-1:0]`
  - selection `sel[1:0]` = {sel1, sel0}
  - step history `step_q`
  - ping-pong direction `pp_dir`, only when the macro is defined
- Reset (`reset_n`=0 at a rising edge):
  - `cnt`=0, `sel`=2'b00, `tick`=0, `wrap`=0, `pp_dir`=up.
  - `step_q`=1, so a `step` held high through reset does not advance. `step` must go low, then high.
- Prescaler:
  - `run`=1: `cnt` increments each cycle. At `cnt`==DIV_MAX it returns to 0 and raises an auto event.
  - `run`=0: `cnt` is forced to 0 and no auto event occurs.
- Manual event: `step & ~step_q`. `step_q` <= `step` every non-reset cycle. A manual event also clears `cnt` to 0.
- Advance: the OR of the auto and manual events. If both occur in the same cycle, exactly one advance happens.
- Direction, normal mode:
  - `dir`=0: `sel` <= `sel`+1 mod 4. `wrap` when 3→0.
  - `dir`=1: `sel` <= `sel`-1 mod 4. `wrap` when 0→3.
  - `dir` is sampled in the cycle of the advance.
- `tick` and `wrap` are registered outputs. `tick`=1 exactly in the cycle after every advance edge, aligned with the new `sel`. Both outputs are 0 otherwise.
- With no advance, `sel` holds and `tick`=`wrap`=0.

## Timing
- Auto advance with `run` held 1 from reset release: `sel` changes at the (DIV_MAX+1)th rising edge after the first non-reset edge, then every DIV_MAX+1 edges.
- Manual latency: `step` high at rising edge k (low at k-1) → `sel` updated and `tick`=1 after edge k.
- Reset mid-sequence: the next rising edge with `reset_n`=0 restores all reset values. Any pending `cnt` progress is discarded.
- Changing `dir` between advances never causes an extra or skipped step.

## Configuration
- `MUX_SEL_SEQ_BOUNCE_EN` defined:
  - While `bounce`=1, `dir` is ignored and `sel` moves by `pp_dir`.
  - On arriving at 3, `pp_dir` <= down. On arriving at 0, `pp_dir` <= up. `wrap` pulses on each arrival at 3 or 0.
  - Sequence from reset: 0,1,2,3,2,1,0,1…
  - `pp_dir` holds its value while `bounce`=0.
- `MUX_SEL_SEQ_BOUNCE_EN` not defined:
  - The `bounce` port is present but ignored, and the `pp_dir` register is absent.
  - Behaviour is identical to `bounce`=0.

## Test plan
- Reset, DIV_MAX=3, `run`=1, `dir`=0, 20 cycles → `sel` goes 1,2,3,0,1 every 4 cycles. `tick` pulses 5 times. `wrap` pulses once, on 3→0.
- `run`=0, `dir`=1, three isolated `step` pulses from `sel`=0 → `sel`=3 (with `wrap`=1), then 2, then 1. Exactly one `tick` per pulse. `step` held high for 5 cycles → one advance only.
- `run`=1, DIV_MAX=3, `step` edge in the same cycle as `cnt`==3 → single advance. Next auto advance comes 4 cycles later.
- `step` high through reset and after release → no advance until `step` goes low then high. Reset asserted with `sel`=2 mid-count → `sel`=0, `tick`=0 after the next edge.
- Macro defined, `bounce`=1, DIV_MAX=0, 8 cycles from reset → `sel` = 1,2,3,2,1,0,1,2. `wrap` at the 3 and the 0.
- Macro undefined, same stimulus → `sel` = 1,2,3,0,1,2,3,0. `wrap` on each 3→0.
